// File: rtl/miner_msg_uart_tx.sv
// Serialises the low MSG_BYTES of msg as 8N1 UART frames, MSB byte first; MINER_MSG_TX_CRLF_EN appends 0D 0A.
// Start bit one cycle after the accepting edge; requests arriving while busy are dropped and counted.
module miner_msg_uart_tx #(
  parameter int CLKS_PER_BIT = 26,
  parameter int MSG_BYTES    = 9
) (
  input  logic          CLOCK_3,
  input  logic          reset,
  input  logic [1023:0] msg,
  input  logic          delivery_msg,
  output logic          uart_tx,
  output logic          busy,
  output logic          dropped,
  output logic [7:0]    drop_count
);

`ifdef MINER_MSG_TX_CRLF_EN
  localparam int TOTAL_BYTES = MSG_BYTES + 2;
`else
  localparam int TOTAL_BYTES = MSG_BYTES;
`endif
  localparam int         BUF_W     = MSG_BYTES * 8;
  localparam logic [7:0]  LAST_IDX  = 8'(TOTAL_BYTES - 1);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [BUF_W-1:0] msg_buf;
  logic [15:0]      baud_cnt, baud_cnt_nxt;
  logic [7:0]       byte_idx, byte_idx_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic             prev_dm, req, bit_done, load, shift, tx_nxt;
  logic [7:0]       cur_byte;

  assign req      = delivery_msg & ~prev_dm;
  assign bit_done = (baud_cnt == BAUD_LAST);

`ifdef MINER_MSG_TX_CRLF_EN
  always_comb begin
    cur_byte = msg_buf[BUF_W-1 -: 8];
    if (byte_idx == 8'(MSG_BYTES))
      cur_byte = 8'h0D;
    else if (byte_idx > 8'(MSG_BYTES))
      cur_byte = 8'h0A;
  end
`else
  assign cur_byte = msg_buf[BUF_W-1 -: 8];
`endif

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    byte_idx_nxt = byte_idx;
    bit_idx_nxt  = bit_idx;
    load         = 1'b0;
    shift        = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt    = START;
          baud_cnt_nxt = 16'd0;
          byte_idx_nxt = 8'd0;
          load         = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_nxt    = DATA;
          bit_idx_nxt  = 3'd0;
          baud_cnt_nxt = 16'd0;
        end else begin
          baud_cnt_nxt = baud_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_nxt = 16'd0;
          if (bit_idx == 3'd7)
            state_nxt = STOP;
          else
            bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          baud_cnt_nxt = baud_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          baud_cnt_nxt = 16'd0;
          // Next byte starts immediately: no idle gap inside a report.
          if (byte_idx < LAST_IDX) begin
            byte_idx_nxt = byte_idx + 8'd1;
            state_nxt    = START;
            shift        = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          baud_cnt_nxt = baud_cnt + 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line level is registered from next-state so the serial output never glitches.
  always_comb begin
    tx_nxt = 1'b1;
    if (state_nxt == START)
      tx_nxt = 1'b0;
    else if (state_nxt == DATA)
      tx_nxt = cur_byte[bit_idx_nxt];
  end

  always_ff @(posedge CLOCK_3) begin
    if (!reset) begin
      state      <= IDLE;
      msg_buf    <= '0;
      baud_cnt   <= 16'd0;
      byte_idx   <= 8'd0;
      bit_idx    <= 3'd0;
      prev_dm    <= 1'b1;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
      dropped    <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      byte_idx <= byte_idx_nxt;
      bit_idx  <= bit_idx_nxt;
      prev_dm  <= delivery_msg;
      uart_tx  <= tx_nxt;
      busy     <= (state_nxt != IDLE);
      dropped  <= req && (state != IDLE);
      if (load)
        msg_buf <= msg[BUF_W-1:0];
      else if (shift)
        msg_buf <= msg_buf << 8;
      if (req && (state != IDLE) && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;
    end
  end

  generate
    if (BUF_W < 1024) begin : g_unused
      logic unused_msg_hi;
      assign unused_msg_hi = ^msg[1023:BUF_W];
    end
  endgenerate

endmodule

// File: tb/tb_miner_msg_uart_tx.sv
// Bench for miner_msg_uart_tx: waveform-queue model checked every cycle plus literal frame checks.
`timescale 1ns/1ps
module tb_miner_msg_uart_tx;
  localparam int C      = 4;
  localparam int NB_MSG = 9;
`ifdef MINER_MSG_TX_CRLF_EN
  localparam int NB       = NB_MSG + 2;
  localparam int EXP_BUSY = 440;
`else
  localparam int NB       = NB_MSG;
  localparam int EXP_BUSY = 360;
`endif
  localparam int FRAME = 10 * C * NB;
  localparam int WIN   = FRAME + 40;

  logic          CLOCK_3 = 1'b0;
  logic          reset;
  logic [1023:0] msg;
  logic          delivery_msg;
  logic          uart_tx, busy, dropped;
  logic [7:0]    drop_count;

  int checks = 0;
  int errors = 0;

  logic [1023:0] report;
  logic [7:0]    exp_bytes [NB];
  logic          cap_line [WIN];
  int            cap_busy, cap_drop;

  miner_msg_uart_tx #(.CLKS_PER_BIT(C), .MSG_BYTES(NB_MSG)) dut (
    .CLOCK_3(CLOCK_3), .reset(reset), .msg(msg), .delivery_msg(delivery_msg),
    .uart_tx(uart_tx), .busy(busy), .dropped(dropped), .drop_count(drop_count)
  );

  always #5 CLOCK_3 = ~CLOCK_3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of line levels, one entry per cycle still to be shown.
  bit mq[$];
  bit m_prev, m_dropped, m_valid = 1'b0, m_was_busy, m_req;
  int m_cnt;

  function automatic void push_report(input logic [1023:0] m);
    logic [7:0] b;
    for (int i = 0; i < NB; i++) begin
      if (i < NB_MSG) b = m[8*(NB_MSG-1-i) +: 8];
      else            b = (i == NB_MSG) ? 8'h0D : 8'h0A;
      for (int s = 0; s < 10; s++)
        for (int r = 0; r < C; r++)
          mq.push_back(s == 0 ? 1'b0 : (s == 9 ? 1'b1 : b[s-1]));
    end
  endfunction

  always @(posedge CLOCK_3) begin
    if (!reset) begin
      mq.delete();
      m_prev = 1'b1; m_dropped = 1'b0; m_cnt = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_was_busy = (mq.size() != 0);
      if (m_was_busy) void'(mq.pop_front());
      m_req     = delivery_msg && !m_prev;
      m_prev    = delivery_msg;
      m_dropped = m_req && m_was_busy;
      if (m_dropped && m_cnt < 255) m_cnt++;
      if (m_req && !m_was_busy) push_report(msg);
    end
  end

  always @(negedge CLOCK_3) begin
    if (m_valid) begin
      chk("uart_tx", 32'(uart_tx), 32'((mq.size() != 0) ? mq[0] : 1'b1));
      chk("busy", 32'(busy), 32'(mq.size() != 0));
      chk("dropped", 32'(dropped), 32'(m_dropped));
      chk("drop_count", 32'(drop_count), 32'(m_cnt[7:0]));
    end
  end

  task automatic kick();
    @(negedge CLOCK_3);
    msg = report;
    delivery_msg = 1'b0;
    @(negedge CLOCK_3);
    delivery_msg = 1'b1;
  endtask

  // Records the line from the cycle after the accepting edge; optionally raises a second edge at edge_at.
  task automatic capture(input int edge_at, input int win);
    cap_busy = 0;
    cap_drop = 0;
    for (int k = 0; k < win; k++) begin
      @(negedge CLOCK_3);
      cap_line[k] = uart_tx;
      if (busy) cap_busy++;
      if (dropped) cap_drop++;
      if (k == 5) msg = ~msg;
      if (edge_at >= 0 && k == edge_at - 2) delivery_msg = 1'b0;
      if (edge_at >= 0 && k == edge_at) delivery_msg = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] b;
    chk({tag, "_start_bit"}, 32'(cap_line[0]), 32'd0);
    chk({tag, "_busy_cycles"}, 32'(cap_busy), 32'(EXP_BUSY));
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < 8; j++)
        b[j] = cap_line[i*10*C + (j+1)*C + C/2];
      chk($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp_bytes[i]));
    end
  endtask

  initial begin
    int n_busy, n_drop;
    report = '0;
    report[71:0] = 72'h5E2121_02F7A2_C02121;
    exp_bytes[0] = 8'h5E; exp_bytes[1] = 8'h21; exp_bytes[2] = 8'h21;
    exp_bytes[3] = 8'h02; exp_bytes[4] = 8'hF7; exp_bytes[5] = 8'hA2;
    exp_bytes[6] = 8'hC0; exp_bytes[7] = 8'h21; exp_bytes[8] = 8'h21;
`ifdef MINER_MSG_TX_CRLF_EN
    exp_bytes[9] = 8'h0D; exp_bytes[10] = 8'h0A;
`endif

    // Strobe already high through reset must not start a frame.
    reset = 1'b0;
    delivery_msg = 1'b1;
    msg = report;
    repeat (3) @(negedge CLOCK_3);
    chk("reset_uart_tx", 32'(uart_tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_dropped", 32'(dropped), 32'd0);
    chk("reset_drop_count", 32'(drop_count), 32'd0);
    reset = 1'b1;
    n_busy = 0; n_drop = 0;
    repeat (50) begin
      @(negedge CLOCK_3);
      if (busy) n_busy++;
      if (dropped) n_drop++;
    end
    chk("reset_high_busy", 32'(n_busy), 32'd0);
    chk("reset_high_drops", 32'(n_drop), 32'd0);

    // Single report.
    kick();
    capture(-1, WIN);
    check_frame("single");
    chk("single_drops", 32'(cap_drop), 32'd0);

    // Strobe held high after the frame.
    n_busy = 0; n_drop = 0;
    repeat (1000) begin
      @(negedge CLOCK_3);
      if (busy) n_busy++;
      if (dropped) n_drop++;
    end
    chk("held_busy", 32'(n_busy), 32'd0);
    chk("held_drops", 32'(n_drop), 32'd0);

    // Overrun at cycle 100; msg also changes mid-frame.
    kick();
    capture(100, WIN);
    check_frame("overrun");
    chk("overrun_pulses", 32'(cap_drop), 32'd1);
    chk("overrun_drop_count", 32'(drop_count), 32'd1);

    // Edge on the last STOP cycle is dropped, edge one cycle after busy falls is taken.
    kick();
    capture(FRAME - 1, FRAME + 1);
    chk("boundary_pulses", 32'(cap_drop), 32'd1);
    chk("boundary_busy", 32'(cap_busy), 32'(EXP_BUSY));
    chk("boundary_busy_low", 32'(busy), 32'd0);
    chk("boundary_drop_count", 32'(drop_count), 32'd2);
    delivery_msg = 1'b0;
    msg = report;
    @(negedge CLOCK_3);
    delivery_msg = 1'b1;
    capture(-1, WIN);
    check_frame("after_boundary");

    // Saturation: toggle the strobe for 700 cycles.
    kick();
    repeat (700) begin
      @(negedge CLOCK_3);
      delivery_msg = ~delivery_msg;
    end
    delivery_msg = 1'b0;
    n_busy = 0;
    while (busy && n_busy < 2 * FRAME) begin
      @(negedge CLOCK_3);
      n_busy++;
    end
    chk("sat_idle_timeout", 32'(busy), 32'd0);
    chk("sat_drop_count", 32'(drop_count), 32'd255);

    // Reset during DATA bit 3 of byte 4.
    kick();
    for (int k = 0; k <= 4*10*C + 4*C + 1; k++) @(negedge CLOCK_3);
    reset = 1'b0;
    @(negedge CLOCK_3);
    chk("midreset_uart_tx", 32'(uart_tx), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_drop_count", 32'(drop_count), 32'd0);
    reset = 1'b1;
    kick();
    capture(-1, WIN);
    check_frame("post_reset");
    chk("post_reset_drop_count", 32'(drop_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
